// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transceiver.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: two-flop synchroniser, start-bit qualification and mid-bit sampling.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      rx_serial,
    output logic [UART_DATA_BITS-1:0] rx_byte,
    output logic                      rx_valid
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(UART_DATA_BITS - 1);

    logic                      rx_meta;
    logic                      rx_sync;
    uart_state_t               state, state_d;
    logic [CNT_W-1:0]          cnt, cnt_d;
    logic [2:0]                bit_idx, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift, shift_d;
    logic [UART_DATA_BITS-1:0] rx_byte_d;
    logic                      rx_valid_d;
    logic                      armed, armed_d;

    // Metastability guard on the asynchronous line
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta <= UART_IDLE_LEVEL;
            rx_sync <= UART_IDLE_LEVEL;
        end else begin
            rx_meta <= rx_serial;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            armed    <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bit_idx  <= bit_idx_d;
            shift    <= shift_d;
            rx_byte  <= rx_byte_d;
            rx_valid <= rx_valid_d;
            armed    <= armed_d;
        end
    end

    // armed forces a high line before each start bit, so a break cannot retrigger
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        bit_idx_d  = bit_idx;
        shift_d    = shift;
        rx_byte_d  = rx_byte;
        rx_valid_d = 1'b0;
        armed_d    = armed;

        unique case (state)
            IDLE: begin
                cnt_d = '0;
                if (rx_sync) begin
                    armed_d = 1'b1;
                end else if (armed) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_sync ? IDLE : DATA;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_sync, shift[UART_DATA_BITS-1:1]};
                    bit_idx_d = bit_idx + 3'd1;
                    if (bit_idx == IDX_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_d   = '0;
                    armed_d = 1'b0;
                    state_d = IDLE;
                    if (rx_sync) begin
                        rx_byte_d  = shift;
                        rx_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex 8N1 UART: receiver in uart_rx, transmitter FSM inline.
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115_200
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      rx_serial,
    output logic                      tx_serial,
    output logic [UART_DATA_BITS-1:0] rx_byte,
    output logic                      rx_valid,
    input  logic [UART_DATA_BITS-1:0] tx_byte,
    input  logic                      tx_start,
    output logic                      tx_busy
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT) + 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       IDX_LAST = 3'(UART_DATA_BITS - 1);

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .CLK       (CLK),
        .RST       (RST),
        .rx_serial (rx_serial),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid)
    );

    uart_state_t               tx_state, tx_state_d;
    logic [CNT_W-1:0]          tx_cnt, tx_cnt_d;
    logic [2:0]                tx_idx, tx_idx_d;
    logic [UART_DATA_BITS-1:0] tx_shift, tx_shift_d;
    logic                      tx_serial_d;
    logic                      tx_busy_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_state  <= IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_shift  <= '0;
            tx_serial <= UART_IDLE_LEVEL;
            tx_busy   <= 1'b0;
        end else begin
            tx_state  <= tx_state_d;
            tx_cnt    <= tx_cnt_d;
            tx_idx    <= tx_idx_d;
            tx_shift  <= tx_shift_d;
            tx_serial <= tx_serial_d;
            tx_busy   <= tx_busy_d;
        end
    end

    // Line level is registered one bit ahead so each bit starts on its boundary edge
    always_comb begin
        tx_state_d  = tx_state;
        tx_cnt_d    = tx_cnt;
        tx_idx_d    = tx_idx;
        tx_shift_d  = tx_shift;
        tx_serial_d = tx_serial;
        tx_busy_d   = tx_busy;

        unique case (tx_state)
            IDLE: begin
                tx_serial_d = UART_IDLE_LEVEL;
                tx_busy_d   = 1'b0;
                tx_cnt_d    = '0;
                if (tx_start && !tx_busy) begin
                    tx_shift_d  = tx_byte;
                    tx_busy_d   = 1'b1;
                    tx_serial_d = 1'b0;
                    tx_idx_d    = '0;
                    tx_state_d  = START;
                end
            end
            START: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d    = '0;
                    tx_serial_d = tx_shift[0];
                    tx_shift_d  = {1'b0, tx_shift[UART_DATA_BITS-1:1]};
                    tx_state_d  = DATA;
                end else begin
                    tx_cnt_d = tx_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d = '0;
                    tx_idx_d = tx_idx + 3'd1;
                    if (tx_idx == IDX_LAST) begin
                        tx_serial_d = UART_IDLE_LEVEL;
                        tx_state_d  = STOP;
                    end else begin
                        tx_serial_d = tx_shift[0];
                        tx_shift_d  = {1'b0, tx_shift[UART_DATA_BITS-1:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_busy_d  = 1'b0;
                    tx_state_d = IDLE;
                end else begin
                    tx_cnt_d = tx_cnt + CNT_W'(1);
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_xcvr.sv
// Scoreboard bench for uart_xcvr at 16 clocks per bit.
module tb_uart_xcvr;

    localparam int CPB = 16;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       rx_drv = 1'b1;
    logic       loop_en = 1'b0;
    logic       rx_serial;
    logic       tx_serial;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy;

    assign rx_serial = loop_en ? tx_serial : rx_drv;

    uart_xcvr #(
        .CLK_FREQ  (16_000_000),
        .BAUD_RATE (1_000_000)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .rx_serial (rx_serial),
        .tx_serial (tx_serial),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .tx_byte   (tx_byte),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rst_epoch = 0;
    int rx_seen = 0;
    int last_valid_cyc = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (RST) rst_epoch <= rst_epoch + 1;
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // RX scoreboard: every rx_valid pulse must match the oldest expected byte
    always @(negedge CLK) begin
        if (rx_valid === 1'b1) begin
            rx_seen++;
            last_valid_cyc = cyc;
            if (rx_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rx_unexpected got=%0h exp=none", rx_byte);
            end else begin
                check("rx_byte", int'(rx_byte), int'(rx_q.pop_front()));
            end
        end
    end

    // TX line decoder; frames interrupted by reset are discarded
    initial begin : tx_mon
        logic [7:0] d;
        logic       st;
        logic       stp;
        int         ep;
        forever begin
            @(negedge CLK);
            if (!RST && tx_serial === 1'b0) begin
                ep = rst_epoch;
                repeat (CPB / 2) @(negedge CLK);
                st = tx_serial;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge CLK);
                    d[i] = tx_serial;
                end
                repeat (CPB) @(negedge CLK);
                stp = tx_serial;
                if (ep == rst_epoch) begin
                    if (tx_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL tx_unexpected got=%0h exp=none", d);
                    end else begin
                        check("tx_frame", int'({st, stp, d}), int'({1'b0, 1'b1, tx_q.pop_front()}));
                    end
                end
            end
        end
    end

    task automatic rx_send(input logic [7:0] b, input logic stop_bit);
        rx_drv = 1'b0;
        repeat (CPB) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (CPB) @(negedge CLK);
        end
        rx_drv = stop_bit;
        repeat (CPB) @(negedge CLK);
        rx_drv = 1'b1;
    endtask

    task automatic wait_rx(input int n);
        for (int c = 0; c < 400 && rx_seen < n; c++) @(negedge CLK);
        check("rx_count", rx_seen, n);
    endtask

    task automatic tx_send(input logic [7:0] b);
        for (int c = 0; c < 400 && tx_busy; c++) @(negedge CLK);
        if (tx_busy) begin
            checks++;
            failures++;
            $display("FAIL tx_idle_timeout got=busy exp=idle");
        end
        tx_byte  = b;
        tx_start = 1'b1;
        @(negedge CLK);
        tx_start = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int         fall_cyc;
        int         busy_len;
        logic       lv[0:159];
        logic [9:0] exp_lv;
        int         ok;
        int         rises;
        int         gap;
        int         gaps;
        int         max_gap;
        logic       prev;

        // Reset state
        repeat (3) @(negedge CLK);
        check("rst_tx_serial", int'(tx_serial), 1);
        check("rst_tx_busy", int'(tx_busy), 0);
        check("rst_rx_valid", int'(rx_valid), 0);
        check("rst_rx_byte", int'(rx_byte), 0);
        RST = 1'b0;
        repeat (5) @(negedge CLK);

        // RX frame 0x55 and its latency
        rx_q.push_back(8'h55);
        fall_cyc = cyc;
        rx_send(8'h55, 1'b1);
        wait_rx(1);
        check("rx_latency_in_range",
              int'((last_valid_cyc - fall_cyc) >= 150 && (last_valid_cyc - fall_cyc) <= 160), 1);
        repeat (20) @(negedge CLK);

        // Single TX frame 0xA3, full waveform
        tx_q.push_back(8'hA3);
        tx_byte  = 8'hA3;
        tx_start = 1'b1;
        @(negedge CLK);
        tx_start = 1'b0;
        busy_len = 0;
        for (int c = 0; c < 400 && tx_busy; c++) begin
            if (c < 160) lv[c] = tx_serial;
            busy_len++;
            @(negedge CLK);
        end
        check("tx_busy_len", busy_len, 160);
        exp_lv = {1'b1, 8'hA3, 1'b0};
        for (int b = 0; b < 10; b++) begin
            ok = 1;
            for (int k = 0; k < CPB; k++) begin
                if (lv[b * CPB + k] !== exp_lv[b]) ok = 0;
            end
            check($sformatf("tx_level_bit%0d", b), ok, 1);
        end
        check("tx_idle_high", int'(tx_serial), 1);
        repeat (20) @(negedge CLK);

        // Held tx_start: one frame per idle window
        repeat (3) tx_q.push_back(8'h41);
        tx_byte  = 8'h41;
        tx_start = 1'b1;
        rises = 0; gap = 0; gaps = 0; max_gap = 0; prev = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            if (!tx_busy) begin
                gap++;
            end else begin
                if (!prev) begin
                    rises++;
                    if (rises > 1) begin
                        gaps++;
                        if (gap > max_gap) max_gap = gap;
                    end
                end
                gap = 0;
            end
            prev = tx_busy;
        end
        tx_start = 1'b0;
        check("tx_hold_frames", rises, 3);
        check("tx_hold_gaps", gaps, 2);
        check("tx_hold_gap_len", max_gap, 1);
        for (int c = 0; c < 400 && tx_busy; c++) @(negedge CLK);
        repeat (20) @(negedge CLK);

        // Glitch and framing error produce nothing; then a good frame
        rx_drv = 1'b0;
        repeat (4) @(negedge CLK);
        rx_drv = 1'b1;
        repeat (40) @(negedge CLK);
        rx_send(8'h3C, 1'b0);
        repeat (40) @(negedge CLK);
        check("rx_no_pulse_on_errors", rx_seen, 1);
        check("rx_byte_held", int'(rx_byte), 8'h55);
        rx_q.push_back(8'h7E);
        rx_send(8'h7E, 1'b1);
        wait_rx(2);
        repeat (20) @(negedge CLK);

        // Loopback, back-to-back
        loop_en = 1'b1;
        repeat (5) @(negedge CLK);
        foreach (exp_lv[i]) begin end
        tx_q.push_back(8'h00); rx_q.push_back(8'h00);
        tx_q.push_back(8'hFF); rx_q.push_back(8'hFF);
        tx_q.push_back(8'h57); rx_q.push_back(8'h57);
        tx_send(8'h00);
        tx_send(8'hFF);
        tx_send(8'h57);
        wait_rx(5);
        for (int c = 0; c < 400 && tx_busy; c++) @(negedge CLK);
        repeat (20) @(negedge CLK);
        loop_en = 1'b0;
        repeat (20) @(negedge CLK);

        // Reset mid-TX (bit 4) and mid-RX
        fork
            rx_send(8'hFF, 1'b1);
            begin
                tx_byte  = 8'h86;
                tx_start = 1'b1;
                @(negedge CLK);
                tx_start = 1'b0;
                repeat (87) @(negedge CLK);
                check("tx_bit4_before_rst", int'(tx_serial), 0);
                RST = 1'b1;
                @(negedge CLK);
                check("rst_mid_tx_serial", int'(tx_serial), 1);
                check("rst_mid_tx_busy", int'(tx_busy), 0);
                check("rst_mid_rx_valid", int'(rx_valid), 0);
                RST = 1'b0;
            end
        join
        repeat (50) @(negedge CLK);
        check("rx_aborted_no_pulse", rx_seen, 5);
        check("rx_byte_after_rst", int'(rx_byte), 0);
        rx_q.push_back(8'hA5);
        rx_send(8'hA5, 1'b1);
        wait_rx(6);
        tx_q.push_back(8'h5A);
        tx_send(8'h5A);

        // Drain scoreboards
        for (int c = 0; c < 1000 && (tx_q.size() != 0 || rx_q.size() != 0); c++) @(negedge CLK);
        check("tx_q_drained", tx_q.size(), 0);
        check("rx_q_drained", rx_q.size(), 0);
        repeat (20) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
